// File: rtl/wbram_pkg.sv
// rtl/wbram_pkg.sv - shared constants and helpers for the Wishbone RAMs
// Read-latency bounds and the word-address width helper.
package wbram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int addr_word_w(input int addr_w, input int num_bytes);
    return addr_w - $clog2(num_bytes);
  endfunction

endpackage

// File: rtl/wbram_port_ctl.sv
// rtl/wbram_port_ctl.sv - per-port accept, ack pipeline and optional output register
// Acks shift READ_LATENCY deep and are flushed whenever the port's cycle is dropped.
module wbram_port_ctl
  import wbram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cyc,
  input  logic                  i_stb,
  input  logic                  i_we,
  input  logic                  i_stall,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_accept,
  output logic                  o_ack,
  output logic [DATA_WIDTH-1:0] o_dat
);

  logic [READ_LATENCY-1:0] r_ack;

  assign o_accept = i_cyc & i_stb & ~i_stall;
  assign o_ack    = r_ack[READ_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= '0;
    end else if (!i_cyc) begin
      r_ack <= '0;
    end else begin
      r_ack[0] <= o_accept;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_ack[i] <= r_ack[i-1];
      end
    end
  end

  generate
    if (READ_LATENCY > 1) begin : g_oreg
      logic                  r_rd;
      logic [DATA_WIDTH-1:0] r_dat;

      // Only a live read in the middle stage may refresh the output word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd  <= 1'b0;
          r_dat <= '0;
        end else begin
          r_rd <= o_accept & ~i_we;
          if (i_cyc && r_ack[0] && r_rd) begin
            r_dat <= i_rdata;
          end
        end
      end

      assign o_dat = r_dat;
    end else begin : g_noreg
      logic w_unused_we;

      assign w_unused_we = i_we;
      assign o_dat       = i_rdata;
    end
  endgenerate

endmodule

// File: rtl/wbram2p.sv
// rtl/wbram2p.sv - dual-port Wishbone B4 pipelined RAM with byte-lane writes
// Define WBRAM2P_COLLISION_EN to stall port B on same-word conflicts with a write.
module wbram2p
  import wbram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int BYTE_WIDTH   = 8,
  parameter int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_wb_cyc_i,
  input  logic                  a_wb_stb_i,
  input  logic                  a_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] a_wb_adr_i,
  input  logic [DATA_WIDTH-1:0] a_wb_dat_i,
  input  logic [NUM_BYTES-1:0]  a_wb_sel_i,
  output logic [DATA_WIDTH-1:0] a_wb_dat_o,
  output logic                  a_wb_ack_o,
  output logic                  a_wb_stall_o,
  input  logic                  b_wb_cyc_i,
  input  logic                  b_wb_stb_i,
  input  logic                  b_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] b_wb_adr_i,
  input  logic [DATA_WIDTH-1:0] b_wb_dat_i,
  input  logic [NUM_BYTES-1:0]  b_wb_sel_i,
  output logic [DATA_WIDTH-1:0] b_wb_dat_o,
  output logic                  b_wb_ack_o,
  output logic                  b_wb_stall_o
);

  localparam int LO     = $clog2(NUM_BYTES);
  localparam int WORD_W = addr_word_w(ADDR_WIDTH, NUM_BYTES);
  localparam int DEPTH  = 1 << WORD_W;

  generate
    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX ||
        DATA_WIDTH != NUM_BYTES * BYTE_WIDTH) begin : g_bad_cfg
      $error("wbram2p: illegal READ_LATENCY or data/byte width combination");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;
  logic [WORD_W-1:0]     w_a_word;
  logic [WORD_W-1:0]     w_b_word;
  logic                  w_a_acc;
  logic                  w_b_acc;
  logic                  w_conflict;
  logic                  w_unused_lo;

  assign w_a_word    = a_wb_adr_i[ADDR_WIDTH-1:LO];
  assign w_b_word    = b_wb_adr_i[ADDR_WIDTH-1:LO];
  assign w_unused_lo = ^{a_wb_adr_i[LO-1:0], b_wb_adr_i[LO-1:0]};

`ifdef WBRAM2P_COLLISION_EN
  logic w_a_req;
  logic w_b_req;

  assign w_a_req    = a_wb_cyc_i & a_wb_stb_i;
  assign w_b_req    = b_wb_cyc_i & b_wb_stb_i;
  assign w_conflict = w_a_req & w_b_req & (w_a_word == w_b_word) & (a_wb_we_i | b_wb_we_i);
`else
  assign w_conflict = 1'b0;
`endif

  assign a_wb_stall_o = 1'b0;
  assign b_wb_stall_o = w_conflict;

  wbram_port_ctl #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_cyc   (a_wb_cyc_i),
    .i_stb   (a_wb_stb_i),
    .i_we    (a_wb_we_i),
    .i_stall (1'b0),
    .i_rdata (r_a_rdata),
    .o_accept(w_a_acc),
    .o_ack   (a_wb_ack_o),
    .o_dat   (a_wb_dat_o)
  );

  wbram_port_ctl #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_cyc   (b_wb_cyc_i),
    .i_stb   (b_wb_stb_i),
    .i_we    (b_wb_we_i),
    .i_stall (w_conflict),
    .i_rdata (r_b_rdata),
    .o_accept(w_b_acc),
    .o_ack   (b_wb_ack_o),
    .o_dat   (b_wb_dat_o)
  );

  // Read-first: the registered word is the value before this cycle's writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (w_a_acc && !a_wb_we_i) begin
        r_a_rdata <= r_mem[w_a_word];
      end
      if (w_b_acc && !b_wb_we_i) begin
        r_b_rdata <= r_mem[w_b_word];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (w_a_acc && a_wb_we_i && a_wb_sel_i[i]) begin
        r_mem[w_a_word][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_wb_dat_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (w_b_acc && b_wb_we_i && b_wb_sel_i[i]) begin
        r_mem[w_b_word][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_wb_dat_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_wbram2p.sv
// tb/tb_wbram2p.sv - bench for wbram2p at read latency 1 and 2 against a word-array model
// Both latency builds share one stimulus stream; WBRAM2P_COLLISION_EN selects conflict rules.
module tb_wbram2p;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NB = 4;
  localparam int RB = 96;
`ifdef WBRAM2P_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0] a_adr, b_adr;
  logic [DW-1:0] a_dat, b_dat;
  logic [NB-1:0] a_sel, b_sel;
  logic [DW-1:0] a_dat_o [2];
  logic [DW-1:0] b_dat_o [2];
  logic          a_ack_o [2];
  logic          b_ack_o [2];
  logic          a_stall_o [2];
  logic          b_stall_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wbram2p #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .NUM_BYTES(NB), .READ_LATENCY(g + 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_wb_cyc_i(a_cyc), .a_wb_stb_i(a_stb), .a_wb_we_i(a_we), .a_wb_adr_i(a_adr),
      .a_wb_dat_i(a_dat), .a_wb_sel_i(a_sel), .a_wb_dat_o(a_dat_o[g]),
      .a_wb_ack_o(a_ack_o[g]), .a_wb_stall_o(a_stall_o[g]),
      .b_wb_cyc_i(b_cyc), .b_wb_stb_i(b_stb), .b_wb_we_i(b_we), .b_wb_adr_i(b_adr),
      .b_wb_dat_i(b_dat), .b_wb_sel_i(b_sel), .b_wb_dat_o(b_dat_o[g]),
      .b_wb_ack_o(b_ack_o[g]), .b_wb_stall_o(b_stall_o[g])
    );
  end

  typedef struct {
    int            due;
    bit            rd;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          q_exp [4][$];
  logic [DW-1:0] mdl [1024];
  int            cyc_now;
  int            n_checks;
  int            n_errors;
  bit            b_stalled_last;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_now);
    end
  endtask

  task automatic model_step();
    bit   a_req, b_req, stall, a_acc, b_acc, ack;
    int   aw, bw, idx;
    logic [DW-1:0] dat;
    exp_t e;
    aw = int'(a_adr[AW-1:2]);
    bw = int'(b_adr[AW-1:2]);
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst a_ack L%0d", d + 1), DW'(a_ack_o[d]), '0);
        chk($sformatf("rst b_ack L%0d", d + 1), DW'(b_ack_o[d]), '0);
        chk($sformatf("rst a_dat L%0d", d + 1), a_dat_o[d], '0);
        chk($sformatf("rst b_dat L%0d", d + 1), b_dat_o[d], '0);
        chk($sformatf("rst a_stall L%0d", d + 1), DW'(a_stall_o[d]), '0);
      end
      for (int i = 0; i < 4; i++) q_exp[i].delete();
      b_stalled_last = 1'b0;
      cyc_now++;
      return;
    end
    a_req = a_cyc && a_stb;
    b_req = b_cyc && b_stb;
    stall = COLL && a_req && b_req && (aw == bw) && (a_we || b_we);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("a_stall L%0d", d + 1), DW'(a_stall_o[d]), '0);
      chk($sformatf("b_stall L%0d", d + 1), DW'(b_stall_o[d]), DW'(stall));
      for (int p = 0; p < 2; p++) begin
        idx = d * 2 + p;
        ack = (p == 0) ? a_ack_o[d] : b_ack_o[d];
        dat = (p == 0) ? a_dat_o[d] : b_dat_o[d];
        if (q_exp[idx].size() > 0 && q_exp[idx][0].due == cyc_now) begin
          e = q_exp[idx].pop_front();
          chk($sformatf("ack %s L%0d", (p == 0) ? "A" : "B", d + 1), DW'(ack), DW'(1));
          if (e.rd) chk($sformatf("dat %s L%0d", (p == 0) ? "A" : "B", d + 1), dat, e.d);
        end else begin
          chk($sformatf("noack %s L%0d", (p == 0) ? "A" : "B", d + 1), DW'(ack), '0);
        end
      end
    end
    a_acc = a_req;
    b_acc = b_req && !stall;
    if (!a_cyc) begin q_exp[0].delete(); q_exp[2].delete(); end
    if (!b_cyc) begin q_exp[1].delete(); q_exp[3].delete(); end
    for (int d = 0; d < 2; d++) begin
      if (a_acc) begin
        e.due = cyc_now + d + 1; e.rd = !a_we; e.d = mdl[aw];
        q_exp[d*2].push_back(e);
      end
      if (b_acc) begin
        e.due = cyc_now + d + 1; e.rd = !b_we; e.d = mdl[bw];
        q_exp[d*2+1].push_back(e);
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (a_acc && a_we && a_sel[i]) mdl[aw][i*8 +: 8] = a_dat[i*8 +: 8];
      if (b_acc && b_we && b_sel[i]) mdl[bw][i*8 +: 8] = b_dat[i*8 +: 8];
    end
    b_stalled_last = b_req && stall;
    cyc_now++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit cyc, input bit stb, input bit we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [NB-1:0] sel);
    a_cyc = cyc; a_stb = stb; a_we = we; a_adr = adr; a_dat = dat; a_sel = sel;
  endtask

  task automatic drive_b(input bit cyc, input bit stb, input bit we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [NB-1:0] sel);
    b_cyc = cyc; b_stb = stb; b_we = we; b_adr = adr; b_dat = dat; b_sel = sel;
  endtask

  task automatic idle_all();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic idle_ticks(input int n);
    idle_all();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    cyc_now = 0; n_checks = 0; n_errors = 0; b_stalled_last = 1'b0;
    rst_n = 1'b0;
    idle_all();
    tick(); tick();
    rst_n = 1'b1;

    // preload words used by the directed cases
    drive_a(1, 1, 1, 12'h010, 32'hCAFEF00D, 4'hF);
    drive_b(1, 1, 1, 12'h080, 32'h12345678, 4'hF);
    tick();
    drive_a(1, 1, 1, 12'h020, 32'hDEADBEEF, 4'hF);
    drive_b(0, 0, 0, '0, '0, '0);
    tick();

    // byte lanes
    drive_a(1, 1, 1, 12'h040, 32'hAABBCCDD, 4'hF); tick();
    drive_a(1, 1, 1, 12'h040, 32'h11223344, 4'b0101); tick();
    drive_a(1, 1, 0, 12'h041, '0, 4'hF); tick();
    idle_ticks(3);

    // overwrite then read back on the next cycle
    drive_a(1, 1, 1, 12'h020, 32'h0, 4'hF); tick();
    drive_a(1, 1, 0, 12'h020, '0, 4'hF); tick();
    idle_ticks(3);

    // back-to-back streams on both ports
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 1, 1, AW'(12'h100 + 4 * i), $urandom, 4'hF); tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 1, 0, AW'(12'h100 + 4 * i), '0, 4'hF);
      drive_b(1, 1, 1, AW'(12'h200 + 4 * i), $urandom, 4'hF);
      tick();
    end
    idle_ticks(3);

    // same-word write on A against read on B
    drive_a(1, 1, 1, 12'h080, 32'h5A5A5A5A, 4'hF);
    drive_b(1, 1, 0, 12'h080, '0, 4'hF);
    tick();
    drive_a(0, 0, 0, '0, '0, '0);
    if (b_stalled_last) tick();
    idle_ticks(3);

    // B burst aborted by dropping cyc
    drive_b(1, 1, 1, 12'h300, 32'h0BADC0DE, 4'hF); tick();
    for (int i = 0; i < 3; i++) begin
      drive_b(1, 1, 0, 12'h300, '0, 4'hF); tick();
    end
    idle_ticks(4);
    drive_a(1, 1, 0, 12'h300, '0, 4'hF); tick();
    idle_ticks(3);

    // reset with two reads in flight
    drive_a(1, 1, 0, 12'h010, '0, 4'hF); tick();
    drive_a(1, 1, 0, 12'h040, '0, 4'hF); tick();
    idle_all();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    idle_ticks(3);
    drive_a(1, 1, 0, 12'h010, '0, 4'hF); tick();
    idle_ticks(3);

    // randomized traffic over a small shared region
    for (int i = 0; i < 16; i++) begin
      drive_a(1, 1, 1, AW'((RB + i) * 4), $urandom, 4'hF); tick();
    end
    for (int c = 0; c < 400; c++) begin
      int wa, wb;
      wa = int'($urandom % 8);
      wb = COLL ? int'($urandom % 8) : 8 + int'($urandom % 8);
      drive_a(($urandom % 8) != 0, ($urandom % 4) != 0, 1'($urandom),
              AW'((RB + wa) * 4 + int'($urandom % 4)), $urandom, NB'($urandom));
      if (!b_stalled_last) begin
        drive_b(($urandom % 8) != 0, ($urandom % 4) != 0, 1'($urandom),
                AW'((RB + wb) * 4 + int'($urandom % 4)), $urandom, NB'($urandom));
      end
      tick();
    end
    idle_ticks(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
